simple_register8: RTL and testbench

SIMPLE_REGISTER8 -- requirements
Module: simple_register8

---
 rtl/simple_register8.sv | 62 ++++++
 tb/tb_simple_register8.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/simple_register8.sv
// Enable-gated data register with asynchronous active-high reset and a sticky
// "loaded since reset" flag. Each data bit is its own cell, instantiated per bit.

module simple_register8_bit #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);
  logic bit_d, bit_q;

  always_comb begin
    bit_d = bit_q;
    if (en) bit_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bit_q <= RST_BIT;
    else     bit_q <= bit_d;
  end

  assign q = bit_q;
endmodule

module simple_register8 #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);
  logic valid_d, valid_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    simple_register8_bit #(.RST_BIT(RST_VAL[i])) u_bit (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (d[i]),
      .q   (q[i])
    );
  end

  // Sticky: once any load happens, only reset clears it.
  always_comb begin
    valid_d = valid_q | en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  assign q_valid = valid_q;
endmodule

// File: tb/tb_simple_register8.sv
// Bench for simple_register8: table-driven loads/holds through a scoreboard queue,
// plus hand sequences for reset, async reset, glitches and the width sweep.

module tb_simple_register8;
  logic        clk = 1'b0;
  logic        rst, en;
  logic [7:0]  d8;
  logic [0:0]  d1;
  logic [31:0] d32;
  logic [7:0]  q8;
  logic [0:0]  q1;
  logic [31:0] q32;
  logic        v8, v1, v32;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  simple_register8 #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .d(d8), .q(q8), .q_valid(v8));
  simple_register8 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .d(d1), .q(q1), .q_valid(v1));
  simple_register8 #(.WIDTH(32), .RST_VAL(32'hDEADBEEF)) u_dut32 (
    .clk(clk), .rst(rst), .en(en), .d(d32), .q(q32), .q_valid(v32));

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic [7:0] q;
    logic       v;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       v;
    int         idx;
  } exp_t;

  vec_t tbl[12];
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_and_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check($sformatf("vec%0d_q", e.idx), 64'(q8), 64'(e.q));
      check($sformatf("vec%0d_v", e.idx), 64'(v8), 64'(e.v));
    end
  endtask

  initial begin
    // en, d, expected q, expected q_valid after the edge
    tbl[0]  = '{1'b0, 8'hFF, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 8'hA5, 8'hA5, 1'b1};
    tbl[2]  = '{1'b1, 8'h3C, 8'h3C, 1'b1};
    tbl[3]  = '{1'b1, 8'h0F, 8'h0F, 1'b1};
    tbl[4]  = '{1'b0, 8'hFF, 8'h0F, 1'b1};
    tbl[5]  = '{1'b0, 8'hFF, 8'h0F, 1'b1};
    tbl[6]  = '{1'b0, 8'hFF, 8'h0F, 1'b1};
    tbl[7]  = '{1'b1, 8'hFF, 8'hFF, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 8'hFF, 1'b1};
    tbl[9]  = '{1'b1, 8'h00, 8'h00, 1'b1};
    tbl[10] = '{1'b1, 8'h80, 8'h80, 1'b1};
    tbl[11] = '{1'b1, 8'h01, 8'h01, 1'b1};

    // Reset held with load requested and clock running
    rst = 1'b1; en = 1'b1; d8 = 8'hFF; d1 = 1'b1; d32 = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_q8",  64'(q8),  64'h00);
    check("rst_v8",  64'(v8),  64'h0);
    check("rst_q32", 64'(q32), 64'hDEADBEEF);
    check("rst_q1",  64'(q1),  64'h0);
    check("rst_v32", 64'(v32), 64'h0);

    @(negedge clk);
    rst = 1'b0; en = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      en = tbl[i].en;
      d8 = tbl[i].d;
      sb.push_back('{tbl[i].q, tbl[i].v, i});
      @(posedge clk);
      #1;
      pop_and_check();
    end

    // Async reset with clk low, checked before the next rising edge
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_clk_low", 64'(clk), 64'h0);
    check("arst_q8", 64'(q8), 64'h00);
    check("arst_v8", 64'(v8), 64'h0);
    en = 1'b1; d8 = 8'h55;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("arst_rel_q8", 64'(q8), 64'h55);
    check("arst_rel_v8", 64'(v8), 64'h1);

    // Glitches on d between edges: only the value present at the edge counts
    @(negedge clk);
    d8 = 8'h11; #1 d8 = 8'h22; #1 d8 = 8'h33;
    @(posedge clk);
    #1;
    check("glitch_edge1", 64'(q8), 64'h33);
    d8 = 8'h44; #1 d8 = 8'hC3; #1;
    check("glitch_mid", 64'(q8), 64'h33);
    @(negedge clk);
    d8 = 8'h99; #2 d8 = 8'h6A;
    @(posedge clk);
    #1;
    check("glitch_edge2", 64'(q8), 64'h6A);

    // Reset mid-operation leaves no trace: no load after release keeps reset state
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("norez_q8", 64'(q8), 64'h00);
    check("norez_v8", 64'(v8), 64'h0);

    // Width sweep: 32-bit with non-zero reset value, and 1-bit
    @(negedge clk);
    rst = 1'b1; en = 1'b1; d32 = 32'h12345678; d1 = 1'b1;
    #1;
    check("sw_rst_q32", 64'(q32), 64'hDEADBEEF);
    @(posedge clk);
    #1;
    check("sw_prio_q32", 64'(q32), 64'hDEADBEEF);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("sw_ld_q32", 64'(q32), 64'h12345678);
    check("sw_ld_v32", 64'(v32), 64'h1);
    check("sw_ld_q1",  64'(q1),  64'h1);
    @(negedge clk);
    d1 = 1'b0; d32 = 32'h8000_0001;
    @(posedge clk);
    #1;
    check("sw_ld2_q1",  64'(q1),  64'h0);
    check("sw_ld2_v1",  64'(v1),  64'h1);
    check("sw_ld2_q32", 64'(q32), 64'h80000001);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1);
  end
endmodule
